key_extract: RTL
================

KEY_EXTRACT -- requirements
Module: key_extract

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 96, meaning width of the emitted lookup key.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning number of pending keys buffered (power of two).
REQ-003 SHALL have parameter CTRL_PORT, default 16'd5000, meaning the UDP destination port that marks insert-type packets.
REQ-004 SHALL have port clk  input  1  meaning the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port s_axis_tdata  input  64  meaning the packet stream; byte 0 of each beat is in tdata[7:0].
REQ-007 SHALL have port s_axis_tkeep  input  8  meaning per-byte valid flags for the beat.
REQ-008 SHALL have port s_axis_tvalid  input  1  meaning the beat is valid.
REQ-009 SHALL have port s_axis_tlast  input  1  meaning the last beat of the packet.
REQ-010 SHALL have port out_key  output  KEY_SIZE  meaning {src IP, dst IP, dst UDP port, 16'h0}.
REQ-011 SHALL have port out_flag  output  4  meaning the operation code: 4'h1 lookup, 4'h2 insert.
REQ-012 SHALL have port out_valid  output  1  meaning a one-cycle key-issue pulse.
REQ-013 SHALL have port out_ready  input  1  meaning the downstream database stage can accept a key.
REQ-014 SHALL have port pkt_cnt  output  32  meaning the count of keys enqueued.
REQ-015 SHALL have port drop_cnt  output  32  meaning the count of keys lost because the FIFO was full.

Function
REQ-016 SHALL be a passive tap: no backpressure on s_axis, and every valid beat SHALL be consumed.
REQ-017 SHALL run an FSM with states IDLE, HDR, SKIP; IDLE->HDR on a valid non-last beat (beat 0); HDR counts beats 1..4; any state->IDLE on a valid tlast beat.
REQ-018 SHALL check the header: beat1 bytes 4-5 = 16'h0800 and byte 6 = 8'h45; beat2 byte 7 = 8'h11 (UDP); on any mismatch the FSM SHALL go to SKIP.
REQ-019 SHALL capture the key fields: src IP = beat3 bytes 2-5, dst IP = beat3 bytes 6-7 plus beat4 bytes 0-1, dst port = beat4 bytes 4-5; all fields in network byte order with the first byte as MSB.
REQ-020 SHALL enqueue the key at the clock edge that accepts a passing beat 4, then enter SKIP, or IDLE if beat 4 carries tlast.
REQ-021 SHALL set flag 4'h2 when dst port equals CTRL_PORT, and 4'h1 otherwise.
REQ-022 SHALL discard a packet whose tlast arrives before beat 4, with no enqueue.
REQ-023 SHALL buffer keys in a FIFO_DEPTH-entry FIFO with wrap-around pointers and an occupancy count.
REQ-024 SHALL, on an enqueue while the FIFO is full, drop the new key, keep the contents unchanged, and increment drop_cnt.
REQ-025 SHALL issue keys: out_valid is registered and SHALL rise for exactly one cycle when the FIFO is non-empty, out_ready=1, and out_valid was 0 in the previous cycle, giving at least 1 idle cycle between issues.
REQ-026 SHALL hold out_key and out_flag stable from the out_valid cycle until the next issue.
REQ-027 SHALL pop the FIFO on issue; a simultaneous enqueue and pop SHALL leave the occupancy unchanged.
REQ-028 SHALL have minimum latency of 1 cycle from the enqueue edge to out_valid high on an empty FIFO.
REQ-029 SHALL keep the counters 32-bit wrapping; pkt_cnt increments on each successful enqueue.

Reset
REQ-030 SHALL, on rst, bring the FSM to IDLE, empty the FIFO, and drive out_valid=0, out_key=0, out_flag=0, pkt_cnt=0, drop_cnt=0.
REQ-031 SHALL treat the stream as mid-packet after an rst release during a packet, and SHALL NOT enqueue until the next tlast has been seen (post-reset SKIP).

Configuration
REQ-032 SHALL implement the counters only when macro KEY_EXTRACT_STATS_EN is defined; without the macro, pkt_cnt and drop_cnt SHALL be constant 0, and the FIFO and issue behaviour SHALL be unchanged.

Verification
REQ-033 SHALL pass this scenario: a 64-byte IPv4/UDP packet, src 10.0.0.1, dst 10.0.0.2, dport 53, out_ready=1 -> one out_valid pulse, out_key=96'h0A000001_0A000002_0035_0000, out_flag=4'h1.
REQ-034 SHALL pass this scenario: the same packet with dport 5000 -> out_flag=4'h2; a packet with ethertype 16'h86DD -> no out_valid and pkt_cnt unchanged.
REQ-035 SHALL pass this scenario: 10 back-to-back valid packets with out_ready=0 -> 8 keys held, drop_cnt=2; then out_ready=1 -> 8 pulses spaced 2 cycles apart, in arrival order.
REQ-036 SHALL pass this scenario: a 3-beat packet with tlast on beat 2 -> no enqueue; the next good packet is extracted normally.
REQ-037 SHALL pass this scenario: rst asserted on beat 3 and released on beat 4 -> no key from that packet, all outputs 0; the next packet is extracted.
REQ-038 SHALL pass this scenario: a build without KEY_EXTRACT_STATS_EN -> the REQ-035 run gives the same out_valid sequence, with pkt_cnt=drop_cnt=0.

Source files
------------

// File: rtl/key_extract.sv
// key_extract: passive tap on a 64-bit packet stream that pulls the
// IPv4/UDP 5-tuple subset {src IP, dst IP, dst port} out of each packet,
// queues it in a small FIFO and issues it to a database stage one key at a
// time with at least one idle cycle between issues.
// Optional feature macro: KEY_EXTRACT_STATS_EN enables pkt_cnt/drop_cnt;
// without it both counters read as constant 0.
module key_extract #(
   parameter int          KEY_SIZE   = 96,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] CTRL_PORT  = 16'd5000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [63:0]         s_axis_tdata,
   input  logic [7:0]          s_axis_tkeep,
   input  logic                s_axis_tvalid,
   input  logic                s_axis_tlast,
   output logic [KEY_SIZE-1:0] out_key,
   output logic [3:0]          out_flag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         pkt_cnt,
   output logic [31:0]         drop_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, HDR, SKIP} state_t;

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_beat, w_beat_nxt;
   logic               r_in_pkt;
   logic               w_enq, w_cap3;
   logic [7:0][7:0]    w_b;
   logic [31:0]        r_src;
   logic [15:0]        r_dst_hi;
   logic [15:0]        w_dport;
   logic [95:0]        w_key96;
   logic [KEY_SIZE-1:0] w_key;
   logic [3:0]         w_flag;

   logic [KEY_SIZE-1:0] r_mem_key  [FIFO_DEPTH];
   logic [3:0]          r_mem_flag [FIFO_DEPTH];
   logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [PW:0]         r_count;
   logic                w_full, w_push, w_pop;
   logic                r_out_valid;
   logic [KEY_SIZE-1:0] r_out_key;
   logic [3:0]          r_out_flag;

   // Byte lanes are only ever inspected in full; tkeep carries no extra
   // information for the fixed-offset header fields we look at.
   logic w_unused;
   assign w_unused = &{1'b0, s_axis_tkeep};

   assign w_b = s_axis_tdata;

   // Tracks whether the previous valid beat left us inside a packet. It keeps
   // following the stream during reset so that a reset released mid-packet
   // does not mistake the next beat for a header; an idle stream while in
   // reset is taken as a packet boundary.
   always_ff @(posedge clk) begin
      if (rst)
         r_in_pkt <= s_axis_tvalid & ~s_axis_tlast;
      else if (s_axis_tvalid)
         r_in_pkt <= ~s_axis_tlast;
   end

   // Parser state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   // Parser next state: header checks on beats 1/2, capture on 3, key on 4.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_enq       = 1'b0;
      w_cap3      = 1'b0;
      if (s_axis_tvalid) begin
         case (r_state)
            IDLE: begin
               if (s_axis_tlast)
                  w_state_nxt = IDLE;
               else if (r_in_pkt)
                  w_state_nxt = SKIP;
               else begin
                  w_state_nxt = HDR;
                  w_beat_nxt  = 3'd1;
               end
            end
            HDR: begin
               w_beat_nxt = r_beat + 3'd1;
               case (r_beat)
                  3'd1: if (!(w_b[4] == 8'h08 && w_b[5] == 8'h00 && w_b[6] == 8'h45))
                           w_state_nxt = SKIP;
                  3'd2: if (w_b[7] != 8'h11)
                           w_state_nxt = SKIP;
                  3'd3: w_cap3 = 1'b1;
                  3'd4: begin
                     w_enq       = 1'b1;
                     w_state_nxt = SKIP;
                  end
                  default: w_state_nxt = SKIP;
               endcase
               // A short packet ends here without a key.
               if (s_axis_tlast)
                  w_state_nxt = IDLE;
            end
            SKIP: if (s_axis_tlast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Hold the beat-3 address fields until beat 4 completes the key.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_src    <= '0;
         r_dst_hi <= '0;
      end else if (w_cap3) begin
         r_src    <= {w_b[2], w_b[3], w_b[4], w_b[5]};
         r_dst_hi <= {w_b[6], w_b[7]};
      end
   end

   assign w_dport = {w_b[4], w_b[5]};
   assign w_key96 = {r_src, r_dst_hi, w_b[0], w_b[1], w_dport, 16'h0000};
   assign w_flag  = (w_dport == CTRL_PORT) ? 4'h2 : 4'h1;

   generate
      if (KEY_SIZE > 96) begin : g_pad
         assign w_key = {{(KEY_SIZE-96){1'b0}}, w_key96};
      end else begin : g_fit
         assign w_key = w_key96[95 -: KEY_SIZE];
      end
   endgenerate

   assign w_full = (r_count == DEPTH_C);
   assign w_push = w_enq & ~w_full;
   // Registered one-cycle pulse; blocking re-issue while high forces the gap.
   assign w_pop  = (r_count != '0) & out_ready & ~r_out_valid;

   // FIFO storage; a key arriving while full is discarded.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_key[r_wr_ptr]  <= w_key;
         r_mem_flag[r_wr_ptr] <= w_flag;
      end
   end

   // FIFO pointers wrap naturally (power-of-two depth) and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue stage: key/flag stay put until the next pop replaces them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_key   <= '0;
         r_out_flag  <= '0;
      end else begin
         r_out_valid <= w_pop;
         if (w_pop) begin
            r_out_key  <= r_mem_key[r_rd_ptr];
            r_out_flag <= r_mem_flag[r_rd_ptr];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_key   = r_out_key;
   assign out_flag  = r_out_flag;

`ifdef KEY_EXTRACT_STATS_EN
   logic [31:0] r_pkt_cnt, r_drop_cnt;

   // Wrapping counters of accepted and dropped keys.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push)          r_pkt_cnt  <= r_pkt_cnt + 32'd1;
         if (w_enq && w_full) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign pkt_cnt  = r_pkt_cnt;
   assign drop_cnt = r_drop_cnt;
`else
   assign pkt_cnt  = 32'd0;
   assign drop_cnt = 32'd0;
`endif

endmodule
